lcd_char_display: RTL and testbench



---
 rtl/lcd_char_display.sv | 279 +++++++++++++++++++++++++++
 tb/tb_lcd_char_display.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_display.sv
// HD44780-class character LCD subsystem.
// Holds a COLS x ROWS character buffer written by the host at clock rate, runs the
// panel power-up/init sequence, and copies the buffer to the panel over an 8-bit
// write-only bus whenever its contents change. All panel timing is counted in ticks
// of an internal clock-enable divider.
module lcd_char_display #(
    parameter int CLK_DIV          = 16,
    parameter int COLS             = 16,
    parameter int ROWS             = 2,
    parameter int POWERUP_TICKS    = 50000,
    parameter int E_TICKS          = 2,
    parameter int CMD_WAIT_TICKS   = 128,
    parameter int CLEAR_WAIT_TICKS = 5120,
    // One code point past the last cell is representable so that out-of-range
    // positions can be presented (and ignored) even when COLS*ROWS is a power of two.
    localparam int ADDR_W          = $clog2(COLS * ROWS + 1)
) (
    input  logic              clk,
    input  logic              sysrst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_pos,
    input  logic [7:0]        wr_char,
    output logic              busy,
    output logic              init_done,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_e,
    output logic [7:0]        lcd_data
);

    localparam int DEPTH = COLS * ROWS;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    localparam int T_MAX0 = (POWERUP_TICKS > E_TICKS) ? POWERUP_TICKS : E_TICKS;
    localparam int T_MAX1 = (T_MAX0 > CMD_WAIT_TICKS) ? T_MAX0 : CMD_WAIT_TICKS;
    localparam int T_MAX  = (T_MAX1 > CLEAR_WAIT_TICKS) ? T_MAX1 : CLEAR_WAIT_TICKS;
    localparam int TMR_W  = $clog2(T_MAX + 1);

    localparam logic [TMR_W-1:0] PWR_LAST = TMR_W'(POWERUP_TICKS - 1);
    localparam logic [TMR_W-1:0] E_LAST   = TMR_W'(E_TICKS - 1);
    localparam logic [TMR_W-1:0] CMD_LAST = TMR_W'(CMD_WAIT_TICKS - 1);
    localparam logic [TMR_W-1:0] CLR_LAST = TMR_W'(CLEAR_WAIT_TICKS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic             ROW_LAST = 1'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_REFRESH
    } state_t;

    // Phases of a single byte transfer on the panel bus.
    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_HOLD,
        PH_WAIT
    } phase_t;

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [1:0]        init_idx_q, init_idx_d;
    logic              row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              is_cmd_q, is_cmd_d;
    logic              rs_q, rs_d;
    logic              e_q, e_d;
    logic [7:0]        data_q, data_d;

    logic [DIV_W-1:0]  div_q;
    logic              tick;
    logic              dirty_q;
    logic              pass_start;
    logic              wr_ok;
    logic [TMR_W-1:0]  wait_last;
    logic [7:0]        char_mem [DEPTH];

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;  // 8-bit bus, two lines, 5x8 font
            2'd1:    return 8'h0C;  // display on, cursor off
            2'd2:    return 8'h01;  // clear display
            default: return 8'h06;  // entry mode: increment, no shift
        endcase
    endfunction

    function automatic logic [7:0] row_cmd(input logic row);
        return row ? 8'hC0 : 8'h80;
    endfunction

    function automatic logic [ADDR_W-1:0] buf_index(input logic row, input logic [COL_W-1:0] col);
        return ADDR_W'(int'(row) * COLS + int'(col));
    endfunction

    assign tick  = (div_q == DIV_LAST);
    assign wr_ok = wr_en && (int'(wr_pos) < DEPTH);

    // Free-running clock-enable divider; every panel timing is counted in its ticks.
    always_ff @(posedge clk or negedge sysrst) begin
        if (!sysrst) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Character buffer: host writes land on any clock, blank (space) after reset.
    always_ff @(posedge clk or negedge sysrst) begin
        if (!sysrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                char_mem[i] <= 8'h20;
            end
        end else if (wr_ok) begin
            char_mem[wr_pos] <= wr_char;
        end
    end

    // Dirty flag: a write on the same clock as pass start wins, forcing another pass.
    always_ff @(posedge clk or negedge sysrst) begin
        if (!sysrst) begin
            dirty_q <= 1'b1;
        end else if (wr_ok) begin
            dirty_q <= 1'b1;
        end else if (pass_start) begin
            dirty_q <= 1'b0;
        end
    end

    // Sequencer and panel output registers.
    always_ff @(posedge clk or negedge sysrst) begin
        if (!sysrst) begin
            state_q    <= ST_PWRUP;
            phase_q    <= PH_SETUP;
            timer_q    <= '0;
            init_idx_q <= 2'd0;
            row_q      <= 1'b0;
            col_q      <= '0;
            is_cmd_q   <= 1'b0;
            rs_q       <= 1'b0;
            e_q        <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            timer_q    <= timer_d;
            init_idx_q <= init_idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            is_cmd_q   <= is_cmd_d;
            rs_q       <= rs_d;
            e_q        <= e_d;
            data_q     <= data_d;
        end
    end

    // Next-state logic; everything advances only on tick clocks.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        timer_d    = timer_q;
        init_idx_d = init_idx_q;
        row_d      = row_q;
        col_d      = col_q;
        is_cmd_d   = is_cmd_q;
        rs_d       = rs_q;
        e_d        = e_q;
        data_d     = data_q;
        pass_start = 1'b0;
        // The clear command needs a much longer settle time than any other byte.
        wait_last  = (!rs_q && (data_q == 8'h01)) ? CLR_LAST : CMD_LAST;

        if (tick) begin
            unique case (state_q)
                ST_PWRUP: begin
                    if (timer_q == PWR_LAST) begin
                        state_d    = ST_INIT;
                        phase_d    = PH_SETUP;
                        timer_d    = '0;
                        init_idx_d = 2'd0;
                        rs_d       = 1'b0;
                        e_d        = 1'b0;
                        data_d     = init_cmd(2'd0);
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (dirty_q) begin
                        pass_start = 1'b1;
                        state_d    = ST_REFRESH;
                        phase_d    = PH_SETUP;
                        row_d      = 1'b0;
                        col_d      = '0;
                        is_cmd_d   = 1'b1;
                        rs_d       = 1'b0;
                        data_d     = row_cmd(1'b0);
                    end
                end

                default: begin
                    unique case (phase_q)
                        PH_SETUP: begin
                            phase_d = PH_PULSE;
                            e_d     = 1'b1;
                            timer_d = '0;
                        end

                        PH_PULSE: begin
                            if (timer_q == E_LAST) begin
                                phase_d = PH_HOLD;
                                e_d     = 1'b0;
                            end else begin
                                timer_d = timer_q + 1'b1;
                            end
                        end

                        PH_HOLD: begin
                            phase_d = PH_WAIT;
                            timer_d = '0;
                        end

                        PH_WAIT: begin
                            if (timer_q != wait_last) begin
                                timer_d = timer_q + 1'b1;
                            end else if (state_q == ST_INIT) begin
                                if (init_idx_q == 2'd3) begin
                                    state_d = ST_IDLE;
                                end else begin
                                    init_idx_d = init_idx_q + 2'd1;
                                    phase_d    = PH_SETUP;
                                    rs_d       = 1'b0;
                                    data_d     = init_cmd(init_idx_q + 2'd1);
                                end
                            end else begin
                                // Refresh: row address command, then that row's characters.
                                // Each character is sampled from the buffer as its SETUP begins.
                                if (is_cmd_q) begin
                                    is_cmd_d = 1'b0;
                                    col_d    = '0;
                                    phase_d  = PH_SETUP;
                                    rs_d     = 1'b1;
                                    data_d   = char_mem[buf_index(row_q, '0)];
                                end else if (col_q != COL_LAST) begin
                                    col_d   = col_q + 1'b1;
                                    phase_d = PH_SETUP;
                                    rs_d    = 1'b1;
                                    data_d  = char_mem[buf_index(row_q, col_q + 1'b1)];
                                end else if (row_q != ROW_LAST) begin
                                    row_d    = 1'b1;
                                    is_cmd_d = 1'b1;
                                    phase_d  = PH_SETUP;
                                    rs_d     = 1'b0;
                                    data_d   = row_cmd(1'b1);
                                end else begin
                                    state_d = ST_IDLE;
                                end
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign init_done = (state_q == ST_IDLE) || (state_q == ST_REFRESH);
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = e_q;
    assign lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_char_display.sv
// Self-checking bench for lcd_char_display: captures every bus transfer and
// compares it with the byte stream a buffer model predicts.
module tb_lcd_char_display;

    localparam int CLK_DIV          = 4;
    localparam int COLS             = 4;
    localparam int ROWS             = 2;
    localparam int POWERUP_TICKS    = 10;
    localparam int E_TICKS          = 2;
    localparam int CMD_WAIT_TICKS   = 3;
    localparam int CLEAR_WAIT_TICKS = 8;
    localparam int DEPTH            = COLS * ROWS;
    localparam int ADDR_W           = $clog2(DEPTH + 1);

    // Transfer timing in system clocks, derived from the tick-level protocol.
    localparam int E_CLKS     = E_TICKS * CLK_DIV;
    localparam int GAP_CMD    = (E_TICKS + 1 + CMD_WAIT_TICKS + 1) * CLK_DIV;
    localparam int GAP_CLR    = (E_TICKS + 1 + CLEAR_WAIT_TICKS + 1) * CLK_DIV;
    localparam int FIRST_RISE = (POWERUP_TICKS + 1) * CLK_DIV;
    localparam int DONE_DELAY = (E_TICKS + 1 + CMD_WAIT_TICKS) * CLK_DIV;

    logic              clk = 1'b0;
    logic              sysrst = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_pos = '0;
    logic [7:0]        wr_char = 8'h00;
    logic              busy, init_done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0]        lcd_data;

    lcd_char_display #(
        .CLK_DIV(CLK_DIV), .COLS(COLS), .ROWS(ROWS), .POWERUP_TICKS(POWERUP_TICKS),
        .E_TICKS(E_TICKS), .CMD_WAIT_TICKS(CMD_WAIT_TICKS), .CLEAR_WAIT_TICKS(CLEAR_WAIT_TICKS)
    ) dut (
        .clk(clk), .sysrst(sysrst), .wr_en(wr_en), .wr_pos(wr_pos), .wr_char(wr_char),
        .busy(busy), .init_done(init_done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_e(lcd_e), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic       rw;
        logic [7:0] d;
        int         width;
        bit         stable;
        logic       busy;
        logic       done;
        int         cyc;
    } xfer_t;

    xfer_t      cap[$];
    xfer_t      cur;
    logic       mon_prev_e = 1'b0;
    logic       mon_prev_rs = 1'b0;
    logic [7:0] mon_prev_d = 8'h00;
    int         cyc = 0;

    int         n_asserts = 0;
    int         n_fail = 0;
    logic [7:0] mbuf [DEPTH];
    logic [8:0] exp_q[$];
    int         base = 0;

    // Clocks since the last reset release.
    always @(posedge clk) begin
        if (!sysrst) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Bus monitor: one record per lcd_e pulse, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (!sysrst) begin
            mon_prev_e = 1'b0;
        end else begin
            if (lcd_e && !mon_prev_e) begin
                cur.rs     = lcd_rs;
                cur.rw     = lcd_rw;
                cur.d      = lcd_data;
                cur.width  = 1;
                cur.stable = (lcd_rs === mon_prev_rs) && (lcd_data === mon_prev_d);
                cur.busy   = busy;
                cur.done   = init_done;
                cur.cyc    = cyc;
            end else if (lcd_e) begin
                cur.width = cur.width + 1;
                if (lcd_rs !== cur.rs || lcd_data !== cur.d) cur.stable = 1'b0;
            end else if (mon_prev_e) begin
                if (lcd_rs !== cur.rs || lcd_data !== cur.d) cur.stable = 1'b0;
                cap.push_back(cur);
            end
            mon_prev_e = lcd_e;
        end
        mon_prev_rs = lcd_rs;
        mon_prev_d  = lcd_data;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mbuf[i] = 8'h20;
    endtask

    task automatic do_write(input int pos, input logic [7:0] ch);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_pos  = ADDR_W'(pos);
        wr_char = ch;
        @(negedge clk);
        wr_en   = 1'b0;
        if (pos < DEPTH) mbuf[pos] = ch;
    endtask

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
    endtask

    task automatic push_pass();
        for (int r = 0; r < ROWS; r++) begin
            exp_q.push_back({1'b0, (r != 0) ? 8'hC0 : 8'h80});
            for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, mbuf[r * COLS + c]});
        end
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int k = 0;
        while (cap.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_count"}, cap.size(), n);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic quiet(input string tag, input int n);
        int s = cap.size();
        bit busy_seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        chk({tag, "_no_bytes"}, cap.size(), s);
        chk({tag, "_busy_low"}, busy_seen, 1'b0);
    endtask

    // Wait for and check the expected byte stream, including per-pulse timing.
    task automatic expect_stream(input string tag, input logic exp_done);
        int n = exp_q.size();
        wait_bytes(tag, base + n, n * 60 + 200);
        for (int i = 0; i < n; i++) begin
            if (base + i < cap.size()) begin
                xfer_t x = cap[base + i];
                string t = $sformatf("%s_b%0d", tag, i);
                chk({t, "_byte"}, {x.rs, x.d}, exp_q[i]);
                chk({t, "_ewidth"}, x.width, E_CLKS);
                chk({t, "_stable"}, 32'(x.stable), 1);
                chk({t, "_rw"}, x.rw, 1'b0);
                chk({t, "_busy"}, x.busy, 1'b1);
                chk({t, "_done"}, x.done, exp_done);
                if (i > 0)
                    chk({t, "_gap"}, x.cyc - cap[base + i - 1].cyc,
                        (exp_q[i - 1] == 9'h001) ? GAP_CLR : GAP_CMD);
            end
        end
        base = base + n;
        exp_q.delete();
    endtask

    // Reset release through init and the mandatory first pass.
    task automatic run_init_and_first_pass(input string tag);
        int ib = base;
        int k = 0;
        push_init();
        expect_stream({tag, "_init"}, 1'b0);
        if (ib + 3 < cap.size()) begin
            chk({tag, "_first_rise"}, cap[ib].cyc, FIRST_RISE);
            chk({tag, "_done_low_at_06"}, init_done, 1'b0);
            while (init_done !== 1'b1 && k < 500) begin
                @(negedge clk);
                k++;
            end
            chk({tag, "_done_delay"}, cyc - cap[ib + 3].cyc, DONE_DELAY);
        end
        push_pass();
        expect_stream({tag, "_pass"}, 1'b1);
        wait_idle(tag, 400);
        chk({tag, "_done_high"}, init_done, 1'b1);
    endtask

    initial begin
        logic [7:0] ch;
        int         nbad;
        int         pb;
        int         k;

        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_e", lcd_e, 1'b0);
        chk("rst_rs", lcd_rs, 1'b0);
        chk("rst_rw", lcd_rw, 1'b0);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_busy", busy, 1'b1);
        chk("rst_done", init_done, 1'b0);

        // 1: power-up, init, first blank pass
        sysrst = 1'b1;
        base   = cap.size();
        run_init_and_first_pass("t1");
        quiet("t1", 120);

        // 2: single write while idle triggers exactly one pass
        do_write(5, 8'h41);
        push_pass();
        expect_stream("t2", 1'b1);
        wait_idle("t2", 400);
        quiet("t2", 120);

        // 3: out-of-range write is ignored
        do_write(8, 8'h55);
        quiet("t3", 200);

        // Randomized rounds: stray out-of-range writes, then optionally one valid write
        for (int r = 0; r < 8; r++) begin
            nbad = $urandom_range(0, 2);
            for (int j = 0; j < nbad; j++)
                do_write($urandom_range(DEPTH, (1 << ADDR_W) - 1), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) != 0) begin
                do_write($urandom_range(0, DEPTH - 1), 8'($urandom_range(8'h21, 8'h7E)));
                push_pass();
                expect_stream($sformatf("rnd%0d", r), 1'b1);
                wait_idle($sformatf("rnd%0d", r), 400);
                quiet($sformatf("rnd%0d", r), 60);
            end else begin
                quiet($sformatf("rnd%0d_none", r), 150);
            end
        end

        // 4: write to an already-sent position mid-pass forces a second pass
        do_write(7, 8'($urandom_range(8'h21, 8'h7E)));
        push_pass();
        pb = base;
        wait_bytes("t4_pre", pb + 2, 400);
        do_write(0, 8'h42);
        expect_stream("t4_pass1", 1'b1);
        push_pass();
        expect_stream("t4_pass2", 1'b1);
        wait_idle("t4", 400);
        quiet("t4", 150);

        // 5: reset, then writes during power-up (back-to-back on pos 1, last wins)
        @(negedge clk);
        sysrst = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        sysrst = 1'b1;
        base   = cap.size();
        do_write(0, 8'h41);
        @(negedge clk);
        wr_en = 1'b1; wr_pos = ADDR_W'(1); wr_char = 8'h5A;
        @(negedge clk);
        wr_char = 8'h42;
        @(negedge clk);
        wr_en = 1'b0;
        mbuf[1] = 8'h42;
        do_write(2, 8'h43);
        do_write(3, 8'h44);
        run_init_and_first_pass("t5");
        quiet("t5", 150);

        // 6: reset while lcd_e is high
        do_write(6, 8'($urandom_range(8'h21, 8'h7E)));
        k = 0;
        while (lcd_e !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("t6_e_before", lcd_e, 1'b1);
        chk("t6_done_before", init_done, 1'b1);
        #1;
        sysrst = 1'b0;
        #1;
        chk("t6_e_reset", lcd_e, 1'b0);
        chk("t6_busy_reset", busy, 1'b1);
        chk("t6_done_reset", init_done, 1'b0);
        chk("t6_data_reset", lcd_data, 8'h00);
        model_clear();
        repeat (2) @(negedge clk);
        sysrst = 1'b1;
        base   = cap.size();
        run_init_and_first_pass("t6");
        quiet("t6", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
